mcu_op_sequencer: RTL and testbench
===================================

// Module: mcu_op_sequencer
// PURPOSE
//  Controller that sequences operations into the mcu datapath. It accepts one
//  instruction at a time over a valid/ready port and drives op_code, op0, op2
//  and the write-data bus for exactly one issue cycle. It waits a fixed
//  datapath latency, captures the op1 result and returns it over a
//  valid/ready port. It sits between the instruction source (bench or fetch
//  unit) and the mcu datapath, and is the only driver of the datapath inputs.
// PARAMETERS
//  OP_SZ   32  width of datapath data (op1 result, write data)
//  MEM_SZ  8   width of operand/address selects op0, op2
//  DP_LAT  1   cycles from issue to valid op1 result; legal range 1..15
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-high
//  instr_valid  in   1       instruction offered
//  instr_ready  out  1       sequencer can accept an instruction
//  instr_opcode in   4       0..7 ALU op (0=ADD, 5=OR); 8=MEM_WR; 9..15 illegal
//  instr_src0   in   MEM_SZ  operand/address 0
//  instr_src2   in   MEM_SZ  operand/address 2
//  instr_data   in   OP_SZ   write data, used by MEM_WR only
//  dp_en        out  1       datapath strobe, high for the single issue cycle
//  op_code      out  4       to datapath
//  op0          out  MEM_SZ  to datapath
//  op2          out  MEM_SZ  to datapath
//  wr_data      out  OP_SZ   to datapath "out" input
//  op1          in   OP_SZ   datapath result
//  res_valid    out  1       result available
//  res_ready    in   1       consumer takes result
//  res_data     out  OP_SZ   captured op1
//  res_opcode   out  4       opcode that produced res_data
//  illegal_op   out  1       one-cycle pulse, illegal opcode dropped
//  instr_count  out  16      count of issued instructions (ALU + MEM_WR)
// BEHAVIOUR
//  States: IDLE, ISSUE, WAIT, RESP. Reset value is IDLE.
//  Reset (async): all outputs 0 (instr_ready also 0 while reset is high),
//    latched fields and counters cleared.
//  IDLE: instr_ready=1. Handshake fires on instr_valid&&instr_ready at a
//    rising edge.
//    - Opcode 0..8: latch all fields; next state ISSUE.
//    - Opcode 9..15: no latch; illegal_op=1 next cycle; stay IDLE;
//      instr_count unchanged.
//  ISSUE (1 cycle): dp_en=1; op_code/op0/op2/wr_data driven from latched
//    fields; instr_count+=1 (wraps 0xFFFF->0).
//    - MEM_WR -> IDLE (no result produced).
//    - ALU -> WAIT, loads the latency counter with DP_LAT-1.
//  WAIT: dp_en=0. op_code/op0/op2/wr_data hold the latched values. Counter
//    decrements. When the counter is 0: sample op1 into res_data, latch
//    res_opcode, go to RESP. For DP_LAT=1, WAIT lasts one cycle and samples
//    op1 on the edge after ISSUE.
//  RESP: res_valid=1. res_data/res_opcode stable until the handshake.
//    instr_ready=0. On res_ready -> IDLE, res_valid drops next cycle.
//    No new instruction is accepted in the same cycle as the result
//    handshake.
//  Outside ISSUE/WAIT: op_code, op0, op2, wr_data are 0; dp_en is 0.
//  Throughput: ALU op = 1 (accept) + 1 + DP_LAT + >=1 cycles. MEM_WR = 2
//    cycles.
//  instr_valid while instr_ready=0 is ignored; the source holds its fields.
//  res_ready while res_valid=0 is ignored.
//  Reset mid-operation: in-flight op abandoned, result lost, state IDLE.
// TESTING
//  1 ADD src0=200 src2=220, DP_LAT=1; datapath model op1=420 -> one dp_en
//    pulse with op_code=0, op0=200, op2=220; res_valid with res_data=420,
//    res_opcode=0.
//  2 OR src0=200 src2=220 -> op_code=5; res_data=220 (200|220); res_ready
//    held low 5 cycles -> res_valid and data stable, instr_ready=0
//    throughout.
//  3 MEM_WR data=0xDEADBEEF src0=3 -> dp_en with op_code=8, wr_data=
//    0xDEADBEEF; no res_valid; instr_ready high again 2 cycles after
//    accept.
//  4 opcode=12 offered -> illegal_op pulses once, no dp_en, instr_count
//    unchanged, next ADD processes normally.
//  5 DP_LAT=4, ADD -> op1 sampled exactly 4 cycles after the dp_en cycle;
//    an op1 glitch at cycle 3 is not captured.
//  6 reset asserted during WAIT -> all outputs 0 immediately; after release
//    IDLE with instr_ready=1 and instr_count=0.

Source files
------------

// File: rtl/mcu_op_sequencer.sv
// Issues one instruction at a time into the mcu datapath, waits the fixed
// datapath latency, then returns the captured op1 result over valid/ready.
module mcu_op_sequencer #(
  parameter int unsigned OP_SZ  = 32,
  parameter int unsigned MEM_SZ = 8,
  parameter int unsigned DP_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_opcode,
  input  logic [MEM_SZ-1:0] instr_src0,
  input  logic [MEM_SZ-1:0] instr_src2,
  input  logic [OP_SZ-1:0]  instr_data,
  output logic              dp_en,
  output logic [3:0]        op_code,
  output logic [MEM_SZ-1:0] op0,
  output logic [MEM_SZ-1:0] op2,
  output logic [OP_SZ-1:0]  wr_data,
  input  logic [OP_SZ-1:0]  op1,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OP_SZ-1:0]  res_data,
  output logic [3:0]        res_opcode,
  output logic              illegal_op,
  output logic [15:0]       instr_count
);

  localparam int unsigned CNT_W    = 4;
  localparam logic [3:0]  OP_MEMWR = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] lat_cnt;

  // The op_* outputs double as the latched instruction fields while in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      instr_ready <= 1'b0;
      dp_en       <= 1'b0;
      op_code     <= '0;
      op0         <= '0;
      op2         <= '0;
      wr_data     <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_opcode  <= '0;
      illegal_op  <= 1'b0;
      instr_count <= '0;
    end else begin
      dp_en      <= 1'b0;
      illegal_op <= 1'b0;
      case (state)
        IDLE: begin
          instr_ready <= 1'b1;
          if (instr_valid && instr_ready) begin
            if (instr_opcode <= OP_MEMWR) begin
              state       <= ISSUE;
              instr_ready <= 1'b0;
              dp_en       <= 1'b1;
              op_code     <= instr_opcode;
              op0         <= instr_src0;
              op2         <= instr_src2;
              wr_data     <= instr_data;
            end else begin
              illegal_op <= 1'b1;
            end
          end
        end
        ISSUE: begin
          instr_count <= instr_count + 16'd1;
          if (op_code == OP_MEMWR) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            op_code     <= '0;
            op0         <= '0;
            op2         <= '0;
            wr_data     <= '0;
          end else begin
            state   <= WAIT;
            lat_cnt <= CNT_W'(DP_LAT - 1);
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            state      <= RESP;
            res_valid  <= 1'b1;
            res_data   <= op1;
            res_opcode <= op_code;
            op_code    <= '0;
            op0        <= '0;
            op2        <= '0;
            wr_data    <= '0;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (res_ready) begin
            state       <= IDLE;
            res_valid   <= 1'b0;
            instr_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_op_sequencer.sv
// Directed bench: DP_LAT=1 instance with a small ALU datapath model, and a
// DP_LAT=4 instance whose op1 is driven by hand to probe the sample point.
module tb_mcu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- DP_LAT = 1 instance ----------------
  logic        rst1, iv1, ir1, dpen1, rv1, rr1, ill1;
  logic [3:0]  opc1, opcode1, resop1;
  logic [7:0]  s01, s21, op01, op21;
  logic [31:0] dat1, wd1, op11, rd1;
  logic [15:0] cnt1;

  mcu_op_sequencer #(.OP_SZ(32), .MEM_SZ(8), .DP_LAT(1)) u_dut1 (
    .clk(clk), .reset(rst1), .instr_valid(iv1), .instr_ready(ir1),
    .instr_opcode(opc1), .instr_src0(s01), .instr_src2(s21), .instr_data(dat1),
    .dp_en(dpen1), .op_code(opcode1), .op0(op01), .op2(op21), .wr_data(wd1),
    .op1(op11), .res_valid(rv1), .res_ready(rr1), .res_data(rd1),
    .res_opcode(resop1), .illegal_op(ill1), .instr_count(cnt1)
  );

  // One-cycle datapath: ADD and OR on the issued operands.
  always @(posedge clk) begin
    if (dpen1) begin
      case (opcode1)
        4'd0:    op11 <= 32'(op01) + 32'(op21);
        4'd5:    op11 <= 32'(op01 | op21);
        default: op11 <= 32'd0;
      endcase
    end
  end

  // ---------------- DP_LAT = 4 instance ----------------
  logic        rst4, iv4, ir4, dpen4, rv4, rr4, ill4;
  logic [3:0]  opc4, opcode4, resop4;
  logic [7:0]  s04, s24, op04, op24;
  logic [31:0] dat4, wd4, op14, rd4;
  logic [15:0] cnt4;

  mcu_op_sequencer #(.OP_SZ(32), .MEM_SZ(8), .DP_LAT(4)) u_dut4 (
    .clk(clk), .reset(rst4), .instr_valid(iv4), .instr_ready(ir4),
    .instr_opcode(opc4), .instr_src0(s04), .instr_src2(s24), .instr_data(dat4),
    .dp_en(dpen4), .op_code(opcode4), .op0(op04), .op2(op24), .wr_data(wd4),
    .op1(op14), .res_valid(rv4), .res_ready(rr4), .res_data(rd4),
    .res_opcode(resop4), .illegal_op(ill4), .instr_count(cnt4)
  );

  // Offer one instruction to the DP_LAT=1 instance; returns one cycle after accept.
  task automatic send1(input logic [3:0] opc, input logic [7:0] a, input logic [7:0] b,
                       input logic [31:0] d);
    int n = 0;
    while (ir1 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'(ir1), 32'd1);
    iv1 = 1'b1; opc1 = opc; s01 = a; s21 = b; dat1 = d;
    @(negedge clk);
    iv1 = 1'b0;
  endtask

  initial begin
    rst1 = 1'b1; iv1 = 1'b0; rr1 = 1'b0; opc1 = '0; s01 = '0; s21 = '0; dat1 = '0;
    rst4 = 1'b1; iv4 = 1'b0; rr4 = 1'b0; opc4 = '0; s04 = '0; s24 = '0; dat4 = '0;
    op14 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ir1), 32'd0);
    chk("rst_dp_en", 32'(dpen1), 32'd0);
    chk("rst_res_valid", 32'(rv1), 32'd0);
    chk("rst_count", 32'(cnt1), 32'd0);
    rst1 = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(ir1), 32'd1);

    // 1: ADD 200+220
    send1(4'd0, 8'd200, 8'd220, 32'd0);
    chk("add_dp_en", 32'(dpen1), 32'd1);
    chk("add_op_code", 32'(opcode1), 32'd0);
    chk("add_op0", 32'(op01), 32'd200);
    chk("add_op2", 32'(op21), 32'd220);
    chk("add_busy", 32'(ir1), 32'd0);
    @(negedge clk);
    chk("add_wait_dp_en", 32'(dpen1), 32'd0);
    chk("add_wait_hold_op0", 32'(op01), 32'd200);
    chk("add_wait_no_res", 32'(rv1), 32'd0);
    @(negedge clk);
    chk("add_res_valid", 32'(rv1), 32'd1);
    chk("add_res_data", rd1, 32'd420);
    chk("add_res_opcode", 32'(resop1), 32'd0);
    chk("add_resp_op0_zero", 32'(op01), 32'd0);
    rr1 = 1'b1;
    @(negedge clk);
    rr1 = 1'b0;
    chk("add_res_drop", 32'(rv1), 32'd0);
    chk("add_ready_back", 32'(ir1), 32'd1);
    chk("add_count", 32'(cnt1), 32'd1);

    // 2: OR with backpressure
    send1(4'd5, 8'd200, 8'd220, 32'd0);
    chk("or_op_code", 32'(opcode1), 32'd5);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("or_hold_valid", 32'(rv1), 32'd1);
      chk("or_hold_data", rd1, 32'd220);
      chk("or_hold_opcode", 32'(resop1), 32'd5);
      chk("or_hold_busy", 32'(ir1), 32'd0);
      @(negedge clk);
    end
    rr1 = 1'b1;
    @(negedge clk);
    rr1 = 1'b0;
    chk("or_res_drop", 32'(rv1), 32'd0);
    chk("or_count", 32'(cnt1), 32'd2);

    // 3: MEM_WR
    send1(4'd8, 8'd3, 8'd0, 32'hDEADBEEF);
    chk("wr_dp_en", 32'(dpen1), 32'd1);
    chk("wr_op_code", 32'(opcode1), 32'd8);
    chk("wr_op0", 32'(op01), 32'd3);
    chk("wr_data", wd1, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_ready_back", 32'(ir1), 32'd1);
    chk("wr_dp_en_off", 32'(dpen1), 32'd0);
    chk("wr_data_zero", wd1, 32'd0);
    chk("wr_no_res", 32'(rv1), 32'd0);
    chk("wr_count", 32'(cnt1), 32'd3);

    // 4: illegal opcode, then ADD
    send1(4'd12, 8'd1, 8'd2, 32'd0);
    chk("ill_pulse", 32'(ill1), 32'd1);
    chk("ill_no_dp_en", 32'(dpen1), 32'd0);
    chk("ill_ready", 32'(ir1), 32'd1);
    @(negedge clk);
    chk("ill_pulse_end", 32'(ill1), 32'd0);
    chk("ill_count", 32'(cnt1), 32'd3);
    send1(4'd0, 8'd1, 8'd2, 32'd0);
    chk("post_ill_dp_en", 32'(dpen1), 32'd1);
    repeat (2) @(negedge clk);
    chk("post_ill_res_valid", 32'(rv1), 32'd1);
    chk("post_ill_res_data", rd1, 32'd3);
    rr1 = 1'b1;
    @(negedge clk);
    rr1 = 1'b0;
    chk("post_ill_count", 32'(cnt1), 32'd4);

    // 5: DP_LAT=4, op1 glitch in cycle 3 after issue must not be captured
    chk("l4_ready", 32'(ir4), 32'd1);
    iv4 = 1'b1; opc4 = 4'd0; s04 = 8'd10; s24 = 8'd20;
    @(negedge clk);
    iv4 = 1'b0;
    chk("l4_dp_en", 32'(dpen4), 32'd1);
    op14 = 32'd111;
    repeat (2) @(negedge clk);
    chk("l4_c2_wait", 32'(rv4), 32'd0);
    @(negedge clk);
    op14 = 32'd999;
    chk("l4_c3_wait", 32'(rv4), 32'd0);
    @(negedge clk);
    op14 = 32'd555;
    chk("l4_c4_wait", 32'(rv4), 32'd0);
    @(negedge clk);
    chk("l4_res_valid", 32'(rv4), 32'd1);
    chk("l4_res_data", rd4, 32'd555);
    rr4 = 1'b1;
    @(negedge clk);
    rr4 = 1'b0;
    chk("l4_count", 32'(cnt4), 32'd1);

    // 6: reset during WAIT
    iv4 = 1'b1; opc4 = 4'd5; s04 = 8'd7; s24 = 8'd9;
    @(negedge clk);
    iv4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rw_in_wait_op0", 32'(op04), 32'd7);
    rst4 = 1'b1;
    #1;
    chk("rw_op0", 32'(op04), 32'd0);
    chk("rw_op_code", 32'(opcode4), 32'd5 & 32'd0);
    chk("rw_count", 32'(cnt4), 32'd0);
    chk("rw_ready", 32'(ir4), 32'd0);
    chk("rw_res_valid", 32'(rv4), 32'd0);
    @(negedge clk);
    rst4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rw_idle_ready", 32'(ir4), 32'd1);
    chk("rw_idle_count", 32'(cnt4), 32'd0);
    chk("rw_idle_res_valid", 32'(rv4), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
